mlp_feature_sequencer: RTL and testbench
========================================

Name: mlp_feature_sequencer

Overview:
Upstream sequencing stage for the combinational white-wine MLP regressor. Accepts one 4-bit feature per valid/ready beat and packs 11 features into the regressor's 44-bit input vector. It then holds that vector stable for a programmable settle time, which covers slow printed-logic propagation. It captures the 21-bit regression result and presents it on a valid/ready output with backpressure.

Parameters:
N_FEAT, 11, features per frame
FEAT_W, 4, bits per feature
OUT_W, 21, regressor output width
SETTLE_CYC, 4, cycles the vector is held before capture (legal range 1..255)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  feature beat valid
s_ready  out  1  sequencer accepts a beat
s_data  in  FEAT_W  feature value, unsigned
s_last  in  1  marks the final feature of a frame
mlp_inp  out  N_FEAT*FEAT_W  packed vector to the regressor
mlp_out  in  OUT_W  regressor result (combinational from mlp_inp)
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  OUT_W  captured result
frame_err  out  1  one-cycle pulse on a framing error
err_count  out  8  saturating count of framing errors

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to COLLECT and the feature index goes to 0.
  - mlp_inp, m_data, m_valid, frame_err and err_count all reset to 0.
- s_ready is a decode of state: it is 1 in COLLECT and 0 otherwise, including while rst is high.
- Beat acceptance: a beat is accepted when s_valid && s_ready. Accepted feature k is written to mlp_inp[FEAT_W*k +: FEAT_W], so feature 0 lands at [3:0].
- mlp_inp changes only on accepted beats; it is otherwise held, including through SETTLE and HOLD.
- COLLECT, accepted beat at index k:
  - k < N_FEAT-1 and !s_last: increment k.
  - k == N_FEAT-1 and s_last: go to SETTLE, load the settle counter with SETTLE_CYC-1, reset k to 0.
  - s_last mismatched (s_last at k < N_FEAT-1, or missing at k == N_FEAT-1): framing error.
    - Discard the frame and reset k to 0; already-written mlp_inp bits stay as they are.
    - frame_err pulses high on the next cycle.
    - err_count increments, saturating at 255.
    - Stay in COLLECT.
- SETTLE: s_ready is 0.
  - Counter nonzero: decrement.
  - Counter zero: register mlp_out into m_data, set m_valid, go to HOLD.
- Latency: SETTLE_CYC rising edges after the edge that accepted the last beat, m_data is captured and m_valid rises. Example: SETTLE_CYC = 4 gives 4 edges.
- HOLD:
  - m_valid = 1; m_data is stable until the handshake.
  - On m_valid && m_ready: clear m_valid and go to COLLECT in the same edge.
  - The first beat of the next frame is accepted the cycle after the handshake.
- No frame overlap: one frame is in flight at a time. Best-case period is N_FEAT + SETTLE_CYC + 1 cycles.
- Reset mid-frame or mid-SETTLE: everything returns to reset values immediately (asynchronous); the partial frame is lost with no error flagged.
- m_ready held low is legal indefinitely; the result is held in HOLD.
- s_data is unsigned; there are no arithmetic operations besides the index and counter. The index is 4 bits wide; the counter is 8 bits wide.

Decomposition:
- Shared package mlp_seq_pkg holds:
  - the state enum {COLLECT, SETTLE, HOLD};
  - constants N_FEAT, FEAT_W, OUT_W, and IN_W = N_FEAT*FEAT_W;
  - ERR_CNT_W = 8.
- One natural sub-module, mlp_settle_timer: a loadable down-counter with a zero flag, driven by load/enable from the FSM.
- Packing, error logic and the output register stay in the top module.

Test Plan:
- Frame of 11 zeros with s_last on beat 11, model drives mlp_out = 70594 -> mlp_inp = 0, m_valid rises 4 edges after the last accept, m_data = 0x113C2.
- Features 1,2,...,11 in order -> mlp_inp = 0xBA987654321 held constant through SETTLE and HOLD; s_ready = 0 for the whole of SETTLE/HOLD.
- s_last asserted on beat 5 -> frame_err pulses one cycle and err_count = 1. The next clean 11-beat frame produces a correct result, with no m_valid from the bad frame.
- m_ready held low 20 cycles after m_valid -> m_data stable and s_ready = 0 throughout. Raising m_ready gives the handshake; the next cycle s_ready = 1.
- rst pulsed during SETTLE (counter = 2) -> all outputs are 0 immediately, state is COLLECT, and no m_valid appears.
- 260 consecutive bad frames (missing s_last on beat 11) -> err_count saturates at 255 with no wrap.

Source files
------------

// File: rtl/mlp_seq_pkg.sv
// Shared types and constants for the MLP feature sequencer.
package mlp_seq_pkg;

  localparam int N_FEAT    = 11;
  localparam int FEAT_W    = 4;
  localparam int OUT_W     = 21;
  localparam int IN_W      = N_FEAT * FEAT_W;
  localparam int ERR_CNT_W = 8;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 8;

  // Index of the feature that must carry s_last.
  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N_FEAT - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  typedef enum logic [1:0] {
    COLLECT,
    SETTLE,
    HOLD
  } seq_state_e;

endpackage

// File: rtl/mlp_settle_timer.sv
// Loadable down-counter with a zero flag; it times how long the packed vector
// is held before the regressor result is captured.
module mlp_settle_timer
  import mlp_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: load has priority, otherwise count down and stop at zero.
  always_comb begin
    // NOTE: assign a default first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments only.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mlp_feature_sequencer.sv
// Packs 11 four-bit features into the regressor input vector, holds it for a
// programmable settle time, then captures the result onto a valid/ready port.
module mlp_feature_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 4  // legal range 1..255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [FEAT_W-1:0]    s_data,
  input  logic                 s_last,
  output logic [IN_W-1:0]      mlp_inp,
  input  logic [OUT_W-1:0]     mlp_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_W-1:0]     m_data,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // The counter reaches zero one edge before capture, so load one less.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  seq_state_e           state_d, state_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic [IN_W-1:0]      mlp_inp_d, mlp_inp_q;
  logic [OUT_W-1:0]     m_data_d, m_data_q;
  logic                 m_valid_d, m_valid_q;
  logic                 frame_err_d, frame_err_q;
  logic [ERR_CNT_W-1:0] err_count_d, err_count_q;

  logic tmr_load, tmr_en, tmr_zero;
  logic beat_acc;

  // Gated with rst so no beat looks acceptable while reset is held.
  assign s_ready  = (state_q == COLLECT) && !rst;
  assign beat_acc = s_valid && s_ready;

  mlp_settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (SETTLE_LOAD),
    .zero     (tmr_zero)
  );

  // Next-state logic: feature packing, framing checks, settle and handshake.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mlp_inp_d   = mlp_inp_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    err_count_d = err_count_q;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      COLLECT: begin
        if (beat_acc) begin
          // Written even on a framing error; a discarded frame leaves its bits.
          for (int k = 0; k < N_FEAT; k++) begin
            if (idx_q == IDX_W'(k)) begin
              mlp_inp_d[k*FEAT_W +: FEAT_W] = s_data;
            end
          end
          if ((idx_q == LAST_IDX) && s_last) begin
            state_d  = SETTLE;
            idx_d    = '0;
            tmr_load = 1'b1;
          end else if ((idx_q != LAST_IDX) && !s_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            idx_d       = '0;
            frame_err_d = 1'b1;
            if (err_count_q != ERR_CNT_MAX) begin
              err_count_d = err_count_q + ERR_CNT_W'(1);
            end
          end
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          m_data_d  = mlp_out;
          m_valid_d = 1'b1;
          state_d   = HOLD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      HOLD: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State, packed vector and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      mlp_inp_q   <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mlp_inp_q   <= mlp_inp_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign mlp_inp   = mlp_inp_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_mlp_feature_sequencer.sv
// Self-checking bench for mlp_feature_sequencer with a stand-in regressor.
module tb_mlp_feature_sequencer;
  import mlp_seq_pkg::*;

  localparam int SETTLE_CYC = 4;
  localparam int WAIT_LIMIT = 300;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic [FEAT_W-1:0]    s_data;
  logic                 s_last;
  logic [IN_W-1:0]      mlp_inp;
  logic [OUT_W-1:0]     mlp_out;
  logic                 m_valid;
  logic                 m_ready;
  logic [OUT_W-1:0]     m_data;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_count;

  int checks_total  = 0;
  int checks_passed = 0;
  int exp_err       = 0;
  logic [FEAT_W-1:0] feat_buf [N_FEAT];

  always #5 clk = ~clk;

  // Stand-in regressor: any fixed mixing function works; an all-zero vector
  // gives 70594 (0x113C2).
  function automatic logic [OUT_W-1:0] fake_mlp(input logic [IN_W-1:0] v);
    return v[20:0] ^ v[43:23] ^ {v[9:0], v[42:32]} ^ 21'd70594;
  endfunction

  assign mlp_out = fake_mlp(mlp_inp);

  mlp_feature_sequencer #(.SETTLE_CYC(SETTLE_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .mlp_inp   (mlp_inp),
    .mlp_out   (mlp_out),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  // Reference: feature i occupies nibble i of the packed vector.
  function automatic logic [IN_W-1:0] model_vec();
    logic [IN_W-1:0] v = '0;
    for (int i = 0; i < N_FEAT; i++) v = v | (IN_W'(feat_buf[i]) << (FEAT_W * i));
    return v;
  endfunction

  // Drive n beats from feat_buf back to back; s_last on beat last_idx.
  task automatic send_beats(input int n, input int last_idx);
    int guard;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = feat_buf[i];
      s_last  = (i == last_idx);
      guard   = 0;
      while (!s_ready && guard < WAIT_LIMIT) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= WAIT_LIMIT) begin
        checks_total++;
        $display("FAIL send_beats: s_ready timeout at beat %0d, got s_ready=%b required 1", i, s_ready);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  // Send a clean frame, check latency/stability, hold m_ready low, handshake.
  task automatic run_frame(input string name, input int hold_cycles);
    logic [IN_W-1:0]  exp_vec;
    logic [OUT_W-1:0] exp_res;
    int edges;
    exp_vec = model_vec();
    exp_res = fake_mlp(exp_vec);
    send_beats(N_FEAT, N_FEAT - 1);
    edges = 0;
    while (edges < WAIT_LIMIT) begin
      @(posedge clk);
      #1;
      edges++;
      if (m_valid) break;
      checks_total++;
      if (s_ready !== 1'b0 || mlp_inp !== exp_vec)
        $display("FAIL %s settle: s_ready=%b mlp_inp=%h, required 0 and %h", name, s_ready, mlp_inp, exp_vec);
      else checks_passed++;
    end
    checks_total++;
    if (edges !== SETTLE_CYC)
      $display("FAIL %s latency: got %0d edges, required %0d", name, edges, SETTLE_CYC);
    else checks_passed++;
    checks_total++;
    if (m_data !== exp_res || mlp_inp !== exp_vec)
      $display("FAIL %s result: m_data=%h mlp_inp=%h, required %h and %h", name, m_data, mlp_inp, exp_res, exp_vec);
    else checks_passed++;
    for (int c = 0; c < hold_cycles; c++) begin
      @(posedge clk);
      #1;
      checks_total++;
      if (m_valid !== 1'b1 || m_data !== exp_res || s_ready !== 1'b0 || mlp_inp !== exp_vec)
        $display("FAIL %s hold: m_valid=%b m_data=%h s_ready=%b mlp_inp=%h, required 1 %h 0 %h",
                 name, m_valid, m_data, s_ready, mlp_inp, exp_res, exp_vec);
      else checks_passed++;
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    checks_total++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL %s handshake: m_valid=%b s_ready=%b, required 0 and 1", name, m_valid, s_ready);
    else checks_passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    #12;
    checks_total++;
    if (s_ready !== 1'b0 || mlp_inp !== '0 || m_data !== '0 || m_valid !== 1'b0 ||
        frame_err !== 1'b0 || err_count !== '0)
      $display("FAIL reset: s_ready=%b mlp_inp=%h m_data=%h m_valid=%b frame_err=%b err_count=%0d, required all 0",
               s_ready, mlp_inp, m_data, m_valid, frame_err, err_count);
    else checks_passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks_total++;
    if (s_ready !== 1'b1) $display("FAIL reset_release: s_ready=%b required 1", s_ready);
    else checks_passed++;
    exp_err = 0;
  endtask

  task automatic test_zero_frame();
    for (int i = 0; i < N_FEAT; i++) feat_buf[i] = '0;
    run_frame("zero_frame", 2);
    checks_total++;
    if (m_data !== 21'h113C2) $display("FAIL zero_frame_value: m_data=%h required 113c2", m_data);
    else checks_passed++;
  endtask

  task automatic test_counting_frame();
    for (int i = 0; i < N_FEAT; i++) feat_buf[i] = FEAT_W'(i + 1);
    run_frame("counting_frame", 3);
    checks_total++;
    if (mlp_inp !== 44'hBA987654321) $display("FAIL counting_vec: mlp_inp=%h required ba987654321", mlp_inp);
    else checks_passed++;
  endtask

  task automatic test_framing_error();
    for (int i = 0; i < N_FEAT; i++) feat_buf[i] = FEAT_W'($urandom_range(0, 15));
    send_beats(5, 4);
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    checks_total++;
    if (frame_err !== 1'b1 || err_count !== ERR_CNT_W'(exp_err))
      $display("FAIL frame_err_pulse: frame_err=%b err_count=%0d, required 1 and %0d", frame_err, err_count, exp_err);
    else checks_passed++;
    @(posedge clk);
    #1;
    checks_total++;
    if (frame_err !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL frame_err_after: frame_err=%b m_valid=%b s_ready=%b, required 0 0 1", frame_err, m_valid, s_ready);
    else checks_passed++;
    for (int i = 0; i < N_FEAT; i++) feat_buf[i] = FEAT_W'($urandom_range(0, 15));
    run_frame("frame_after_error", 1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N_FEAT; i++) feat_buf[i] = FEAT_W'($urandom_range(0, 15));
    run_frame("backpressure", 20);
  endtask

  task automatic test_reset_mid_settle();
    for (int i = 0; i < N_FEAT; i++) feat_buf[i] = FEAT_W'($urandom_range(1, 15));
    send_beats(N_FEAT, N_FEAT - 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_err = 0;
    checks_total++;
    if (s_ready !== 1'b0 || mlp_inp !== '0 || m_data !== '0 || m_valid !== 1'b0 ||
        frame_err !== 1'b0 || err_count !== '0)
      $display("FAIL reset_mid_settle: s_ready=%b mlp_inp=%h m_data=%h m_valid=%b frame_err=%b err_count=%0d, required all 0",
               s_ready, mlp_inp, m_data, m_valid, frame_err, err_count);
    else checks_passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks_total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1)
        $display("FAIL reset_mid_settle_after: m_valid=%b s_ready=%b, required 0 and 1", m_valid, s_ready);
      else checks_passed++;
    end
  endtask

  task automatic test_err_saturation();
    for (int f = 0; f < 260; f++) begin
      for (int i = 0; i < N_FEAT; i++) feat_buf[i] = FEAT_W'($urandom_range(0, 15));
      send_beats(N_FEAT, -1);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      checks_total++;
      if (err_count !== ERR_CNT_W'(exp_err) || frame_err !== 1'b1)
        $display("FAIL err_saturation frame %0d: err_count=%0d frame_err=%b, required %0d and 1",
                 f, err_count, frame_err, exp_err);
      else checks_passed++;
    end
    checks_total++;
    if (err_count !== 8'd255) $display("FAIL err_saturation_final: err_count=%0d required 255", err_count);
    else checks_passed++;
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N_FEAT; i++) feat_buf[i] = FEAT_W'($urandom_range(0, 15));
      run_frame("random_frame", int'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_counting_frame();
    test_framing_error();
    test_backpressure();
    test_reset_mid_settle();
    test_random_frames();
    test_err_saturation();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
